// File: rtl/spi_sram_controller.sv
// spi_sram_controller: Wishbone slave turning single-byte accesses into
// SPI SRAM read/write transactions (SPI mode 0, sck = clk/2).
module spi_sram_controller #(
  parameter int ADDR_WIDTH = 24
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_stb_i,
  input  logic [ADDR_WIDTH-1:0] wbs_adr_i,
  input  logic                  wbs_we_i,
  input  logic [7:0]            wbs_dat_i,
  output logic                  wbs_ack_o,
  output logic                  wbs_err_o,
  output logic                  wbs_rty_o,
  output logic [7:0]            wbs_dat_o,
  input  logic [1:0]            sram_config,
  output logic                  spi_cs_n_o,
  output logic                  spi_sck_o,
  output logic                  spi_mosi_o,
  input  logic                  spi_miso_i
);

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR, DUMMY, DATA, DONE, ERR
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        phase_q;
  logic [47:0] sr_q;
  logic [6:0]  rx_q;
  logic [7:0]  dat_q;
  logic [1:0]  cfg_q;
  logic        rd_q;
  logic        abort_q;

  logic        req, bad_adr, accept;
  logic        active, bit_end, last;
  logic [1:0]  cfg_in;
  logic [7:0]  op, wdat;
  logic [47:0] frame;

  assign req     = wbs_cyc_i & wbs_stb_i;
  assign cfg_in  = (sram_config == 2'd3) ? 2'd0 : sram_config;
  assign bad_adr = (cfg_in == 2'd1) &&
                   (|wbs_adr_i[ADDR_WIDTH-1:16]);
  assign accept  = (state_q == IDLE) & req & ~bad_adr;

  assign op   = wbs_we_i ? 8'h02 :
                (cfg_in == 2'd2) ? 8'h0B : 8'h03;
  assign wdat = wbs_we_i ? wbs_dat_i : 8'h00;

  // Whole transaction pre-packed MSB first; dummy/read bits stay 0
  assign frame = (cfg_in == 2'd1) ?
    {op, wbs_adr_i[15:0], wdat, 16'h0000} :
    {op, wbs_adr_i[23:0], wdat, 8'h00};

  assign active  = state_q inside {CMD, ADDR, DUMMY, DATA};
  assign bit_end = active & phase_q;
  assign last    = (cnt_q == 5'd0);

  assign spi_cs_n_o = ~active;
  assign spi_sck_o  = bit_end;
  assign spi_mosi_o = active & sr_q[47];
  assign wbs_ack_o  = (state_q == DONE) & ~abort_q;
  assign wbs_err_o  = (state_q == ERR);
  assign wbs_rty_o  = 1'b0;
  assign wbs_dat_o  = dat_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: if (req) begin
        state_d = bad_adr ? ERR : CMD;
        cnt_d   = 5'd7;
      end
      CMD, ADDR, DUMMY, DATA: if (bit_end) begin
        cnt_d = cnt_q - 5'd1;
        if (last) begin
          cnt_d = 5'd7;
          unique case (state_q)
            CMD: begin
              state_d = ADDR;
              cnt_d   = (cfg_q == 2'd1) ? 5'd15 : 5'd23;
            end
            ADDR:
              state_d = (cfg_q == 2'd2 && rd_q) ? DUMMY : DATA;
            DUMMY:   state_d = DATA;
            default: state_d = DONE;
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      phase_q <= 1'b0;
      sr_q    <= '0;
      rx_q    <= '0;
      dat_q   <= '0;
      cfg_q   <= '0;
      rd_q    <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        phase_q <= 1'b0;
        sr_q    <= frame;
        cfg_q   <= cfg_in;
        rd_q    <= ~wbs_we_i;
        abort_q <= 1'b0;
      end else if (active) begin
        phase_q <= ~phase_q;
        if (!wbs_cyc_i) abort_q <= 1'b1;
        if (phase_q) begin
          sr_q <= {sr_q[46:0], 1'b0};
          rx_q <= {rx_q[5:0], spi_miso_i};
        end
      end
      // Abandoned reads leave the previous byte visible
      if (bit_end && last && state_q == DATA &&
          rd_q && !abort_q && wbs_cyc_i)
        dat_q <= {rx_q, spi_miso_i};
    end
  end

endmodule

// File: tb/tb_spi_sram_controller.sv
// tb_spi_sram_controller: scoreboard bench with a behavioural SPI SRAM
// model; responses and MOSI frames are queued and checked by monitors.
module tb_spi_sram_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc_i = 1'b0, stb = 1'b0, we = 1'b0;
  logic [23:0] adr = '0;
  logic [7:0]  dat = '0;
  logic [1:0]  cfg = '0;
  logic        miso = 1'b0;
  logic        ack, err, rty, cs_n, sck, mosi;
  logic [7:0]  dout;

  int tests = 0, fails = 0, cyc = 0;
  int resp_seen = 0, resp_exp = 0;

  typedef struct {
    bit         is_err;
    bit         chk;
    logic [7:0] data;
    int         due;
  } resp_t;

  typedef struct {
    logic [47:0] bits;
    int          n;
    int          cs;
  } frame_t;

  resp_t  rq[$];
  frame_t fq[$];
  resp_t  e_m;
  frame_t f_m;

  logic [7:0]  mem [logic [23:0]];
  logic        m_addr16 = 1'b0;
  logic [47:0] cap = '0;
  int          nb = 0, lowc = 0;

  spi_sram_controller #(.ADDR_WIDTH(24)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .wbs_cyc_i   (cyc_i),
    .wbs_stb_i   (stb),
    .wbs_adr_i   (adr),
    .wbs_we_i    (we),
    .wbs_dat_i   (dat),
    .wbs_ack_o   (ack),
    .wbs_err_o   (err),
    .wbs_rty_o   (rty),
    .wbs_dat_o   (dout),
    .sram_config (cfg),
    .spi_cs_n_o  (cs_n),
    .spi_sck_o   (sck),
    .spi_mosi_o  (mosi),
    .spi_miso_i  (miso)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] rd_mem(input logic [23:0] a);
    return mem.exists(a) ? mem[a] : 8'hFF;
  endfunction

  // SRAM model: capture MOSI on sck rise, present MISO for the
  // DUT to sample at the end of the same high phase
  int          b, hdr, f_hdr;
  logic [23:0] ma, f_ma;
  logic [7:0]  mb;
  logic [47:0] tmp;

  always @(posedge sck) if (cs_n === 1'b0) begin
    b = nb;
    if (b < 48) cap[47-b] = mosi;
    nb++;
    hdr = 8 + (m_addr16 ? 16 : 24) +
          ((cap[47:40] == 8'h0B) ? 8 : 0);
    ma = m_addr16 ? {8'h00, cap[39:24]} : cap[39:16];
    if (b >= 8 && b >= hdr && b < hdr + 8) begin
      mb = rd_mem(ma);
      miso = mb[7-(b-hdr)];
    end else begin
      miso = 1'b0;
    end
  end

  always @(posedge cs_n) if (nb > 0 || lowc > 0) begin
    f_hdr = 8 + (m_addr16 ? 16 : 24);
    f_ma = m_addr16 ? {8'h00, cap[39:24]} : cap[39:16];
    if (cap[47:40] == 8'h02 && nb == f_hdr + 8) begin
      tmp = cap << f_hdr;
      mem[f_ma] = tmp[47:40];
    end
    if (fq.size() == 0) begin
      check("unexpected cs frame", nb, 0);
    end else begin
      f_m = fq.pop_front();
      check("mosi frame", cap, f_m.bits);
      check("frame bit count", nb, f_m.n);
      check("cs low cycles", lowc, f_m.cs);
    end
    cap = '0;
    nb = 0;
    lowc = 0;
  end

  always @(negedge clk) begin
    if (cs_n === 1'b0) lowc++;
    if (ack === 1'b1 || err === 1'b1) begin
      resp_seen++;
      if (rq.size() == 0) begin
        check("unexpected response", {ack, err}, 2'b00);
      end else begin
        e_m = rq.pop_front();
        check("resp err flag", err, e_m.is_err);
        check("resp cycle", cyc, e_m.due);
        if (e_m.chk) check("read data", dout, e_m.data);
      end
    end
  end

  task automatic drive(input bit w, input logic [23:0] a,
                       input logic [7:0] d, input logic [1:0] c,
                       output int t0);
    @(posedge clk); #1;
    cyc_i = 1'b1; stb = 1'b1; we = w;
    adr = a; dat = d; cfg = c;
    m_addr16 = (c == 2'd1);
    t0 = cyc + 1;
  endtask

  task automatic exp_resp(input bit e, input bit chk,
                          input logic [7:0] d, input int due);
    rq.push_back('{e, chk, d, due});
    resp_exp++;
  endtask

  task automatic exp_frame(input logic [47:0] bits,
                           input int n, input int cs);
    fq.push_back('{bits, n, cs});
  endtask

  task automatic finish_req();
    int k = 0;
    while (resp_seen < resp_exp && k < 300) begin
      @(negedge clk); #1;
      k++;
    end
    check("response timeout", resp_seen < resp_exp, 0);
    @(posedge clk); #1;
    cyc_i = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic xfer(input bit w, input logic [23:0] a,
                      input logic [7:0] d, input logic [1:0] c,
                      input logic [47:0] fr, input int n,
                      input logic [7:0] rdv);
    int t0;
    drive(w, a, d, c, t0);
    exp_frame(fr, n, 2 * n);
    exp_resp(1'b0, !w, rdv, t0 + 2 * n);
    finish_req();
  endtask

  int t0;

  initial begin
    mem[24'h000200] = 8'hA5;
    mem[24'hABCDEF] = 8'h5A;
    mem[24'h000000] = 8'h77;

    repeat (3) @(posedge clk);
    #1;
    check("reset cs_n", cs_n, 1);
    check("reset sck", sck, 0);
    check("reset mosi", mosi, 0);
    check("reset ack", ack, 0);
    check("reset err", err, 0);
    check("reset dat_o", dout, 0);
    check("rty", rty, 0);
    rst = 1'b0;

    xfer(1'b0, 24'h000200, 8'h00, 2'd0,
         48'h030002000000, 40, 8'hA5);

    xfer(1'b1, 24'h001234, 8'h3C, 2'd1,
         48'h0212343C0000, 32, 8'h00);
    check("mem[1234] written", rd_mem(24'h001234), 8'h3C);

    xfer(1'b0, 24'h001234, 8'h00, 2'd1,
         48'h031234000000, 32, 8'h3C);

    drive(1'b0, 24'hABCDEF, 8'h00, 2'd2, t0);
    exp_frame(48'h0BABCDEF0000, 48, 96);
    exp_resp(1'b0, 1'b1, 8'h5A, t0 + 96);
    @(posedge clk); #1;
    cfg = 2'd1;
    finish_req();

    xfer(1'b1, 24'h000010, 8'h81, 2'd2,
         48'h020000108100, 40, 8'h00);
    check("mem[10] written", rd_mem(24'h000010), 8'h81);

    xfer(1'b0, 24'h000010, 8'h00, 2'd3,
         48'h030000100000, 40, 8'h81);

    drive(1'b0, 24'h010000, 8'h00, 2'd1, t0);
    exp_resp(1'b1, 1'b0, 8'h00, t0);
    finish_req();

    drive(1'b0, 24'h000200, 8'h00, 2'd0, t0);
    exp_frame(48'h030000000000, 15, 30);
    while (cyc < t0 + 30) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    check("mid reset cs_n", cs_n, 1);
    check("mid reset sck", sck, 0);
    check("mid reset ack", ack, 0);
    check("mid reset dat_o", dout, 0);
    cyc_i = 1'b0; stb = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    xfer(1'b0, 24'h000000, 8'h00, 2'd0,
         48'h030000000000, 40, 8'h77);

    drive(1'b0, 24'h000200, 8'h00, 2'd0, t0);
    exp_frame(48'h030002000000, 40, 80);
    while (cyc < t0 + 20) begin
      @(posedge clk); #1;
    end
    cyc_i = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
    cyc_i = 1'b1; stb = 1'b1; adr = 24'h000010;
    exp_frame(48'h030000100000, 40, 80);
    exp_resp(1'b0, 1'b1, 8'h81, t0 + 82 + 80);
    finish_req();

    repeat (5) @(posedge clk);
    #1;
    check("resp queue drained", rq.size(), 0);
    check("frame queue drained", fq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
